// File: rtl/sync_hs_src_ctrl.sv
// Source-side controller for a 4-phase req/ack handshake toward another clock domain.
// Acknowledge is synchronized by a 3-flop chain; optional per-phase timeout leads to a sticky error state.
module sync_hs_src_ctrl #(
  parameter int unsigned     DW      = 32,
  parameter int unsigned     TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          xfer_req,
  output logic [DW-1:0] xfer_data,
  input  logic          ack_async,
  output logic          done,
  output logic          err,
  input  logic          err_clr,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO, ERR} state_t;

  localparam logic            TO_EN   = (TIMEOUT != '0);
  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

  state_t          state;
  logic            s0, s1, ack_s;
  logic [TO_W-1:0] cnt;
  logic            to_hit;

  assign to_hit   = TO_EN && (cnt == TO_LAST);
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      s0        <= 1'b0;
      s1        <= 1'b0;
      ack_s     <= 1'b0;
      cnt       <= '0;
    end else begin
      s0    <= ack_async;
      s1    <= s0;
      ack_s <= s1;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            xfer_data <= in_data;
            xfer_req  <= 1'b1;
            cnt       <= '0;
            state     <= REQ_HI;
          end
        end
        REQ_HI: begin
          // Exit condition is tested before the timeout so a coincident ack wins.
          if (ack_s) begin
            xfer_req <= 1'b0;
            cnt      <= '0;
            state    <= REQ_LO;
          end else if (to_hit) begin
            xfer_req <= 1'b0;
            err      <= 1'b1;
            state    <= ERR;
          end else if (cnt != '1) begin
            cnt <= cnt + TO_W'(1);
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (to_hit) begin
            xfer_req <= 1'b0;
            err      <= 1'b1;
            state    <= ERR;
          end else if (cnt != '1) begin
            cnt <= cnt + TO_W'(1);
          end
        end
        ERR: begin
          if (err_clr && !ack_s) begin
            err   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_hs_src_ctrl.sv
// Bench for sync_hs_src_ctrl: two instances (timeout off / timeout 16) driven alike,
// checked every cycle against a transfer-level reference model plus directed timing points.
module tb_sync_hs_src_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        err_clr = 1'b0;
  bit          lb [2];
  bit          ackf [2];

  logic        in_ready0, xfer_req0, done0, err0, busy0, ack0;
  logic [31:0] xfer_data0;
  logic        in_ready1, xfer_req1, done1, err1, busy1, ack1;
  logic [31:0] xfer_data1;

  assign ack0 = lb[0] ? xfer_req0 : ackf[0];
  assign ack1 = lb[1] ? xfer_req1 : ackf[1];

  always #5 clk = ~clk;

  sync_hs_src_ctrl #(.DW(32), .TO_W(16), .TIMEOUT(16'd0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .xfer_req(xfer_req0), .xfer_data(xfer_data0), .ack_async(ack0), .done(done0),
    .err(err0), .err_clr(err_clr), .busy(busy0));

  sync_hs_src_ctrl #(.DW(32), .TO_W(16), .TIMEOUT(16'd16)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .xfer_req(xfer_req1), .xfer_data(xfer_data1), .ack_async(ack1), .done(done1),
    .err(err1), .err_clr(err_clr), .busy(busy1));

  // Reference model: phase 0 idle, 1 waiting for ack high, 2 waiting for ack low, 3 error.
  int          ph [2];
  int          waited [2];
  bit          hist [2][3];
  bit          mreq [2];
  bit          mdone [2];
  bit          merr [2];
  bit          macc [2];
  logic [31:0] mdata [2];

  int ncmp = 0;
  int nfail = 0;
  int ecnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s @edge%0d observed=%0h expected=%0h", tag, ecnt, obs, exp);
    end
  endtask

  task automatic model_edge(input int k);
    int  lim;
    bit  acks;
    bit  ain;
    lim  = (k == 1) ? 16 : 0;
    acks = hist[k][2];
    ain  = lb[k] ? mreq[k] : ackf[k];
    macc[k] = 1'b0;
    if (rst) begin
      ph[k] = 0; waited[k] = 0; mreq[k] = 0; mdone[k] = 0; merr[k] = 0; mdata[k] = '0;
      hist[k][0] = 0; hist[k][1] = 0; hist[k][2] = 0;
    end else begin
      mdone[k] = 0;
      if (ph[k] == 0) begin
        if (in_valid) begin
          mdata[k] = in_data; mreq[k] = 1; waited[k] = 0; ph[k] = 1; macc[k] = 1;
        end
      end else if (ph[k] == 1 || ph[k] == 2) begin
        if ((ph[k] == 1) == acks) begin
          if (ph[k] == 1) begin mreq[k] = 0; waited[k] = 0; ph[k] = 2; end
          else begin mdone[k] = 1; ph[k] = 0; end
        end else if (lim != 0 && waited[k] == lim - 1) begin
          ph[k] = 3; mreq[k] = 0; merr[k] = 1;
        end else begin
          waited[k]++;
        end
      end else begin
        if (err_clr && !acks) begin merr[k] = 0; ph[k] = 0; end
      end
      hist[k][2] = hist[k][1];
      hist[k][1] = hist[k][0];
      hist[k][0] = ain;
    end
  endtask

  task automatic check_all();
    chk("ready0", 64'(in_ready0),  64'(ph[0] == 0));
    chk("busy0",  64'(busy0),      64'(ph[0] != 0));
    chk("req0",   64'(xfer_req0),  64'(mreq[0]));
    chk("data0",  64'(xfer_data0), 64'(mdata[0]));
    chk("done0",  64'(done0),      64'(mdone[0]));
    chk("err0",   64'(err0),       64'(merr[0]));
    chk("ready1", 64'(in_ready1),  64'(ph[1] == 0));
    chk("busy1",  64'(busy1),      64'(ph[1] != 0));
    chk("req1",   64'(xfer_req1),  64'(mreq[1]));
    chk("data1",  64'(xfer_data1), 64'(mdata[1]));
    chk("done1",  64'(done1),      64'(mdone[1]));
    chk("err1",   64'(err1),       64'(merr[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
    ecnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; err_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  logic [31:0] words [3];
  int          accs [3];
  int          idx;

  initial begin
    lb[0] = 0; lb[1] = 0; ackf[0] = 0; ackf[1] = 0;

    // 1: reset then idle
    step(); step();
    rst = 1'b0;
    step();
    chk("t1_ready", 64'(in_ready1), 64'd1);
    chk("t1_busy",  64'(busy1),     64'd0);
    chk("t1_req",   64'(xfer_req1), 64'd0);
    chk("t1_data",  64'(xfer_data1), 64'd0);

    // 2: single loopback transfer; edge 0 is the accepting edge
    lb[0] = 1; lb[1] = 1;
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    ecnt = 0;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 3) chk("t2_req_e3", 64'(xfer_req0), 64'd1);
      if (i == 4) chk("t2_req_e4", 64'(xfer_req0), 64'd0);
      if (i == 7) chk("t2_done_e7", 64'(done0), 64'd0);
      if (i == 8) chk("t2_done_e8", 64'(done0), 64'd1);
      if (i == 9) chk("t2_done_e9", 64'(done0), 64'd0);
    end
    chk("t2_data", 64'(xfer_data0), 64'hDEADBEEF);

    // 3: back-to-back words with in_valid held high
    words[0] = 32'h1111_0001; words[1] = 32'h2222_0002; words[2] = 32'h3333_0003;
    idx = 0;
    in_valid = 1'b1; in_data = words[0];
    ecnt = 0;
    for (int i = 0; i < 30 && idx < 3; i++) begin
      step();
      if (macc[0]) begin
        chk("t3_order", 64'(xfer_data0), 64'(words[idx]));
        accs[idx] = ecnt - 1;
        idx++;
        if (idx < 3) in_data = words[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("t3_count", 64'(idx), 64'd3);
    chk("t3_acc1",  64'(accs[1]), 64'd9);
    chk("t3_acc2",  64'(accs[2]), 64'd18);
    for (int i = 0; i < 10; i++) step();

    // 4: timeout with ack stuck low
    do_reset();
    lb[0] = 0; lb[1] = 0; ackf[0] = 0; ackf[1] = 0;
    in_valid = 1'b1; in_data = 32'hCAFE_F00D;
    ecnt = 0;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      step();
      if (i == 15) chk("t4_err_e15", 64'(err1), 64'd0);
      if (i == 16) begin
        chk("t4_err_e16", 64'(err1), 64'd1);
        chk("t4_req_e16", 64'(xfer_req1), 64'd0);
        chk("t4_busy",    64'(busy1), 64'd1);
        chk("t4_ready",   64'(in_ready1), 64'd0);
      end
    end
    chk("t4_noto0", 64'(err0), 64'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_clr_err",  64'(err1), 64'd0);
    chk("t4_clr_idle", 64'(in_ready1), 64'd1);
    chk("t4_clr_done", 64'(done1), 64'd0);
    step(); step();

    // 5: error clear blocked while synchronized ack is high
    do_reset();
    ackf[0] = 1; ackf[1] = 1;
    in_valid = 1'b1; in_data = 32'h5A5A_A5A5;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 22; i++) step();
    chk("t5_err", 64'(err1), 64'd1);
    err_clr = 1'b1;
    step(); step();
    err_clr = 1'b0;
    chk("t5_blocked", 64'(err1), 64'd1);
    ackf[0] = 0; ackf[1] = 0;
    for (int i = 0; i < 4; i++) step();
    chk("t5_still", 64'(err1), 64'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t5_cleared", 64'(err1), 64'd0);
    chk("t5_idle",    64'(in_ready1), 64'd1);
    chk("t5_data",    64'(xfer_data1), 64'h5A5A_A5A5);

    // 6: reset in the middle of a handshake
    do_reset();
    lb[0] = 1; lb[1] = 1;
    in_valid = 1'b1; in_data = 32'h0BAD_0BAD;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_req",   64'(xfer_req1), 64'd0);
    chk("t6_busy",  64'(busy1), 64'd0);
    chk("t6_ready", 64'(in_ready1), 64'd1);
    chk("t6_sync",  64'({u1.s0, u1.s1, u1.ack_s}), 64'd0);
    chk("t6_sync0", 64'({u0.s0, u0.s1, u0.ack_s}), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) begin
        lb[0] = 1'($urandom_range(0, 1)); lb[1] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 7) == 0) ackf[0] = ~ackf[0];
      if ($urandom_range(0, 7) == 0) ackf[1] = ~ackf[1];
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = $urandom;
      err_clr  = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
